// File: rtl/msu_data_fetch.sv
// MSU data fetch unit: streams bytes from memory into a small show-ahead FIFO.
// A seek restarts the stream at a new byte address; busy reports that the
// stream has not yet buffered enough data since the last seek. One memory read
// is outstanding at most; a read in flight at seek time is drained and its
// returned byte thrown away.

module msu_data_fetch #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned FILL_LEVEL = 8
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        seek,
   input  logic [31:0] seek_addr,
   input  logic        pop,
   output logic [7:0]  data_out,
   output logic        busy,
   output logic        underflow,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_data
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StDrain
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     fetch_addr_q, fetch_addr_d;
   logic [31:0]     req_addr_q, req_addr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      data_out_q, data_out_d;
   logic            busy_q, busy_d;
   logic            underflow_q, underflow_d;

   logic            issue;
   logic            push;
   logic            pop_ok;

   logic [7:0]      ram [DEPTH];

   // Fetch FSM: request issue, ack handling and seek redirection.
   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      issue        = 1'b0;
      push         = 1'b0;

      case (state_q)
         StIdle: begin
            if (seek) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            // A same-cycle seek suppresses the request so no read leaves with a stale address.
            if (seek) begin
               state_d = StIssue;
            end else if (count_q < CW'(DEPTH)) begin
               issue   = 1'b1;
               state_d = StWait;
            end
         end
         StWait: begin
            if (seek) begin
               // An ack in the seek cycle completes the old read, so no drain is needed.
               state_d = mem_ack ? StIssue : StDrain;
            end else if (mem_ack) begin
               push         = 1'b1;
               fetch_addr_d = fetch_addr_q + 32'd1;
               state_d      = StIssue;
            end
         end
         StDrain: begin
            // The returned byte belongs to the abandoned stream and is dropped.
            if (mem_ack) begin
               state_d = StIssue;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (seek) begin
         fetch_addr_d = seek_addr;
      end
   end

   // FIFO pointers, fill count, busy and underflow bookkeeping.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      busy_d      = busy_q;
      underflow_d = underflow_q;
      pop_ok      = 1'b0;

      if (seek) begin
         // Seek wins over a same-cycle pop; the pop is simply lost.
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         busy_d      = 1'b1;
         underflow_d = 1'b0;
      end else begin
         pop_ok = pop && (count_q != '0);
         if (pop && (count_q == '0)) begin
            underflow_d = 1'b1;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         // Busy only ever clears once per seek; later draining does not re-raise it.
         if (busy_q && (count_q >= CW'(FILL_LEVEL))) begin
            busy_d = 1'b0;
         end
      end
   end

   // Next head byte; bypass the RAM when the head slot is being written this cycle.
   always_comb begin
      data_out_d = data_out_q;
      if (count_d != '0) begin
         if (push && (wr_ptr_q == rd_ptr_d)) begin
            data_out_d = mem_data;
         end else begin
            data_out_d = ram[rd_ptr_d];
         end
      end
   end

   // Address presented with a request is latched so it stays valid until the ack.
   always_comb begin
      req_addr_d = issue ? fetch_addr_q : req_addr_q;
   end

   // State and datapath registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= StIdle;
         fetch_addr_q <= '0;
         req_addr_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         data_out_q   <= '0;
         busy_q       <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         req_addr_q   <= req_addr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         data_out_q   <= data_out_d;
         busy_q       <= busy_d;
         underflow_q  <= underflow_d;
      end
   end

   // FIFO storage write port.
   always_ff @(posedge CLK) begin
      if (push) begin
         ram[wr_ptr_q] <= mem_data;
      end
   end

   // Outputs; during the issue cycle the live fetch address is on the bus.
   always_comb begin
      mem_rd    = issue;
      mem_addr  = (state_q == StIssue) ? fetch_addr_q : req_addr_q;
      data_out  = data_out_q;
      busy      = busy_q;
      underflow = underflow_q;
   end

endmodule

// File: tb/tb_msu_data_fetch.sv
// Bench for msu_data_fetch: a latency-programmable memory model answers reads,
// and an expected-byte queue, filled at each seek, is popped as the FIFO drains.

module tb_msu_data_fetch;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        seek;
   logic [31:0] seek_addr;
   logic        pop;
   logic [7:0]  data_out;
   logic        busy;
   logic        underflow;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_data;

   int n_cmp = 0;
   int n_err = 0;

   int          ack_delay   = 1;
   int          ack_total   = 0;
   int          seek_base   = 0;
   int          overlap_cnt = 0;
   bit          outstanding = 1'b0;
   logic [31:0] req_a;
   logic [31:0] rd_log [$];
   logic [7:0]  exp_q [$];

   msu_data_fetch #(
      .DEPTH      (16),
      .FILL_LEVEL (8)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .seek      (seek),
      .seek_addr (seek_addr),
      .pop       (pop),
      .data_out  (data_out),
      .busy      (busy),
      .underflow (underflow),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_data  (mem_data)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
   endfunction

   // Memory: sees a strobe mid-cycle, acks ack_delay cycles after the accepting edge.
   initial begin
      mem_ack  = 1'b0;
      mem_data = 8'h00;
      forever begin
         @(negedge CLK);
         #1;
         if (mem_rd === 1'b1) begin
            req_a = mem_addr;
            rd_log.push_back(req_a);
            @(posedge CLK);
            #1;
            outstanding = 1'b1;
            repeat (ack_delay - 1) begin
               @(posedge CLK);
               #1;
            end
            mem_data = mem_byte(req_a);
            mem_ack  = 1'b1;
            @(posedge CLK);
            #1;
            mem_ack     = 1'b0;
            mem_data    = 8'h00;
            outstanding = 1'b0;
            ack_total++;
         end
      end
   end

   // Any strobe while a read is still open is a protocol violation.
   always @(negedge CLK) begin
      #1;
      if (mem_rd === 1'b1 && outstanding) overlap_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Pulses seek for one cycle and loads the expected stream; settle avoids hitting a WAIT.
   task automatic do_seek(input logic [31:0] a, input bit settle);
      if (settle) begin
         for (int i = 0; i < 50 && outstanding; i++) @(negedge CLK);
      end
      seek      = 1'b1;
      seek_addr = a;
      seek_base = ack_total;
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(mem_byte(a + 32'(i)));
      @(negedge CLK);
      seek = 1'b0;
   endtask

   task automatic test_reset();
      int rd_seen;
      RST_N = 1'b0;
      seek = 1'b0; seek_addr = '0; pop = 1'b0;
      repeat (3) @(negedge CLK);
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_data_out: got %h want 00", data_out); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL rst_underflow: got %b want 0", underflow); end
      n_cmp++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd); end
      n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
      RST_N = 1'b1;
      rd_seen = 0;
      repeat (6) begin
         @(negedge CLK);
         if (mem_rd !== 1'b0) rd_seen++;
      end
      n_cmp++; if (rd_seen != 0) begin n_err++; $display("FAIL idle_no_rd: got %0d strobes want 0", rd_seen); end
   endtask

   task automatic test_fill();
      bit got;
      int extra;
      do_seek(32'h0000_1000, 1'b1);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fill_busy_set: got %b want 1", busy); end
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (busy === 1'b0) begin got = 1'b1; break; end
         @(negedge CLK);
      end
      n_cmp++; if (!got) begin n_err++; $display("FAIL fill_busy_clear: busy still %b want 0", busy); end
      n_cmp++; if (ack_total - seek_base != 8) begin
         n_err++; $display("FAIL fill_pushes_at_ready: got %0d want 8", ack_total - seek_base);
      end
      n_cmp++; if (data_out !== exp_q[0]) begin
         n_err++; $display("FAIL fill_head: got %h want %h", data_out, exp_q[0]);
      end
      for (int i = 0; i < 300 && (ack_total - seek_base < 16); i++) @(negedge CLK);
      extra = 0;
      repeat (12) begin
         @(negedge CLK);
         if (mem_rd !== 1'b0) extra++;
      end
      n_cmp++; if (ack_total - seek_base != 16) begin
         n_err++; $display("FAIL fill_full_count: got %0d want 16", ack_total - seek_base);
      end
      n_cmp++; if (extra != 0) begin n_err++; $display("FAIL fill_stop: got %0d strobes want 0", extra); end
      n_cmp++; if (rd_log[$] !== 32'h0000_100F) begin
         n_err++; $display("FAIL fill_last_addr: got %h want 0000100f", rd_log[$]);
      end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fill_busy_full: got %b want 0", busy); end
   endtask

   task automatic test_pop_stream();
      logic [7:0] exp_b;
      int busy_hi;
      busy_hi = 0;
      for (int i = 0; i < 10; i++) begin
         exp_b = exp_q.pop_front();
         n_cmp++; if (data_out !== exp_b) begin
            n_err++; $display("FAIL pop_data[%0d]: got %h want %h", i, data_out, exp_b);
         end
         if (busy !== 1'b0) busy_hi++;
         pop = 1'b1;
         @(negedge CLK);
      end
      pop = 1'b0;
      n_cmp++; if (busy_hi != 0) begin n_err++; $display("FAIL pop_busy: got %0d busy cycles want 0", busy_hi); end
      for (int i = 0; i < 300 && (ack_total - seek_base < 26); i++) @(negedge CLK);
      repeat (10) @(negedge CLK);
      n_cmp++; if (ack_total - seek_base != 26) begin
         n_err++; $display("FAIL refill_count: got %0d want 26", ack_total - seek_base);
      end
      n_cmp++; if (rd_log[$] !== 32'h0000_1019) begin
         n_err++; $display("FAIL refill_last_addr: got %h want 00001019", rd_log[$]);
      end
      n_cmp++; if (data_out !== exp_q[0]) begin
         n_err++; $display("FAIL refill_head: got %h want %h", data_out, exp_q[0]);
      end
      n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL pop_underflow: got %b want 0", underflow); end
   endtask

   task automatic test_seek_in_wait();
      bit found;
      bit got;
      int rd_before;
      int drop;
      int drain_rd;
      ack_delay = 5;
      do_seek(32'h0000_1000, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (mem_rd === 1'b1 && mem_addr === 32'h0000_1005) begin found = 1'b1; break; end
         @(negedge CLK);
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL wait_reach_1005: got no read want 00001005"); end
      @(negedge CLK);
      rd_before = rd_log.size();
      drop      = ack_total;
      ack_delay = 1;
      do_seek(32'h0000_2000, 1'b0);
      drain_rd = 0;
      for (int i = 0; i < 20 && ack_total == drop; i++) begin
         if (mem_rd !== 1'b0) drain_rd++;
         @(negedge CLK);
      end
      n_cmp++; if (ack_total == drop) begin n_err++; $display("FAIL drain_ack: got no ack want 1"); end
      n_cmp++; if (drain_rd != 0) begin n_err++; $display("FAIL drain_no_rd: got %0d strobes want 0", drain_rd); end
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (busy === 1'b0) begin got = 1'b1; break; end
         @(negedge CLK);
      end
      n_cmp++; if (!got) begin n_err++; $display("FAIL seek2_busy_clear: busy %b want 0", busy); end
      n_cmp++; if (data_out !== exp_q[0]) begin
         n_err++; $display("FAIL seek2_first_byte: got %h want %h", data_out, exp_q[0]);
      end
      n_cmp++; if (rd_log.size() <= rd_before || rd_log[rd_before] !== 32'h0000_2000) begin
         n_err++; $display("FAIL seek2_first_addr: log size %0d want entry 00002000", rd_log.size());
      end
      n_cmp++; if (overlap_cnt != 0) begin n_err++; $display("FAIL single_outstanding: got %0d want 0", overlap_cnt); end
   endtask

   task automatic test_wrap();
      int n0;
      logic [31:0] exp_a;
      n0 = rd_log.size();
      do_seek(32'hFFFF_FFFE, 1'b1);
      for (int i = 0; i < 100 && rd_log.size() < n0 + 4; i++) @(negedge CLK);
      n_cmp++; if (rd_log.size() < n0 + 4) begin
         n_err++; $display("FAIL wrap_reads: got %0d want 4", rd_log.size() - n0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            exp_a = 32'hFFFF_FFFE + 32'(i);
            n_cmp++; if (rd_log[n0 + i] !== exp_a) begin
               n_err++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, rd_log[n0 + i], exp_a);
            end
         end
      end
   endtask

   task automatic test_underflow();
      bit got;
      do_seek(32'h0000_3000, 1'b1);
      pop = 1'b1;
      @(negedge CLK);
      pop = 1'b0;
      n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set: got %b want 1", underflow); end
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (busy === 1'b0) begin got = 1'b1; break; end
         @(negedge CLK);
      end
      n_cmp++; if (!got) begin n_err++; $display("FAIL uf_busy_clear: busy %b want 0", busy); end
      n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky: got %b want 1", underflow); end
      n_cmp++; if (data_out !== exp_q[0]) begin
         n_err++; $display("FAIL uf_head: got %h want %h", data_out, exp_q[0]);
      end
      // Seek together with a pop: the pop must be ignored.
      pop = 1'b1;
      do_seek(32'h0000_4000, 1'b1);
      pop = 1'b0;
      n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_clear: got %b want 0", underflow); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL seek4_busy: got %b want 1", busy); end
      for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge CLK);
      n_cmp++; if (data_out !== exp_q[0]) begin
         n_err++; $display("FAIL seek4_head: got %h want %h", data_out, exp_q[0]);
      end
   endtask

   task automatic test_reset_mid_fill();
      int rd_seen;
      bit found;
      ack_delay = 4;
      do_seek(32'h0000_5000, 1'b1);
      for (int i = 0; i < 200 && (ack_total - seek_base < 5); i++) @(negedge CLK);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (mem_rd === 1'b1) begin found = 1'b1; break; end
         @(negedge CLK);
      end
      n_cmp++; if (!found || ack_total - seek_base != 5) begin
         n_err++; $display("FAIL mid_fill_reach: got %0d pushes want 5", ack_total - seek_base);
      end
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL mrst_data_out: got %h want 00", data_out); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mrst_busy: got %b want 0", busy); end
      n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL mrst_underflow: got %b want 0", underflow); end
      n_cmp++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL mrst_mem_rd: got %b want 0", mem_rd); end
      n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL mrst_mem_addr: got %h want 0", mem_addr); end
      @(negedge CLK);
      RST_N = 1'b1;
      n_cmp++; if (!outstanding) begin n_err++; $display("FAIL mrst_late_ack_pending: got 0 want 1"); end
      rd_seen = 0;
      repeat (100) begin
         @(negedge CLK);
         if (mem_rd !== 1'b0) rd_seen++;
      end
      n_cmp++; if (rd_seen != 0) begin n_err++; $display("FAIL mrst_no_rd: got %0d strobes want 0", rd_seen); end
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL mrst_ack_ignored: got %h want 00", data_out); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mrst_busy_after: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_pop_stream();
      test_seek_in_wait();
      test_wrap();
      test_underflow();
      test_reset_mid_fill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/msu_data_fetch.md
MSU_DATA_FETCH -- requirements
Module: msu_data_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes, a power of 2 and at least 4.
REQ-002 SHALL have parameter FILL_LEVEL, default 8, the byte count at which busy clears after a seek, with 1 <= FILL_LEVEL <= DEPTH.
REQ-003 SHALL have port CLK  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port seek  input  1  one-cycle pulse that loads seek_addr and restarts the stream.
REQ-006 SHALL have port seek_addr  input  32  byte address of the new stream start.
REQ-007 SHALL have port pop  input  1  one-cycle pulse that consumes the FIFO head byte.
REQ-008 SHALL have port data_out  output  8  FIFO head byte (show-ahead).
REQ-009 SHALL have port busy  output  1  stream not ready; feeds the MSU status data-busy bit.
REQ-010 SHALL have port underflow  output  1  sticky flag, set by a pop while the FIFO is empty.
REQ-011 SHALL have port mem_rd  output  1  one-cycle read request strobe.
REQ-012 SHALL have port mem_addr  output  32  byte address of the read, held valid from mem_rd until mem_ack.
REQ-013 SHALL have port mem_ack  input  1  one-cycle pulse; mem_data is valid in that cycle.
REQ-014 SHALL have port mem_data  input  8  returned byte.

Function
REQ-015 SHALL implement the FSM states IDLE, ISSUE, WAIT and DRAIN.
REQ-016 IDLE SHALL issue no requests; it is left only on seek.
REQ-017 ISSUE SHALL move to WAIT with mem_rd=1 for exactly one cycle when count+0 < DEPTH; otherwise it SHALL stay in ISSUE.
REQ-018 WAIT SHALL, on mem_ack, push mem_data, increment the fetch address, and return to ISSUE in the same cycle.
REQ-019 At most one read SHALL be outstanding at any time; mem_rd is never asserted in WAIT or DRAIN.
REQ-020 Seek in IDLE or ISSUE SHALL, in the same cycle, flush the FIFO (count=0), load fetch address=seek_addr, set busy=1, clear underflow, and enter ISSUE.
REQ-021 Seek in WAIT SHALL flush, load the address, set busy=1 and enter DRAIN; the in-flight mem_ack SHALL be discarded, not pushed, after which the FSM enters ISSUE.
REQ-022 Seek in DRAIN SHALL reload the address and remain in DRAIN.
REQ-023 A seek coinciding with mem_ack in WAIT SHALL discard that byte and go directly to ISSUE, since the outstanding read is then complete.
REQ-024 busy SHALL clear in the cycle after count reaches FILL_LEVEL following a seek, or when the fetch stalls on a full FIFO if DEPTH < FILL_LEVEL cannot occur.
REQ-025 Once clear, busy SHALL stay clear until the next seek, regardless of count.
REQ-026 Pop with count>0 SHALL advance the read pointer; data_out SHALL show the next byte the following cycle.
REQ-027 Pop with count=0 SHALL leave pointers unchanged and set underflow.
REQ-028 Simultaneous push and pop SHALL leave count unchanged; a pop on an empty FIFO with a simultaneous push SHALL set underflow and still push.
REQ-029 Seek SHALL have priority over a same-cycle pop, which is ignored.
REQ-030 The fetch address SHALL wrap modulo 2^32 (0xFFFFFFFF to 0x00000000).
REQ-031 The pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH and never overflow, because no request is issued when count=DEPTH.
REQ-032 data_out SHALL be registered from the FIFO RAM head; when count=0 its value is don't-care but stable.

Reset
REQ-033 RST_N low SHALL asynchronously force: FSM=IDLE, count=0, pointers=0, fetch address=0, data_out=0, busy=0, underflow=0, mem_rd=0, mem_addr=0.
REQ-034 Reset asserted during WAIT SHALL abandon the outstanding read; a mem_ack arriving after reset release while in IDLE SHALL be ignored.

Verification
REQ-035 Seek to 0x00001000 with memory answering one cycle after mem_rd SHALL give busy=1, then eight pushes, busy=0 with data_out = byte @0x1000, and fetching SHALL stop at count=16 with the last mem_addr=0x0000100F.
REQ-036 With the FIFO full, ten pops on consecutive cycles SHALL yield bytes @0x1000..0x1009 in order, refill SHALL keep running, and busy SHALL stay 0.
REQ-037 Seek to 0x2000 while in WAIT for 0x1005, with mem_ack delayed 5 cycles, SHALL discard the ack byte, make the first push the byte @0x2000, and give no mem_rd during DRAIN.
REQ-038 Seek to 0xFFFFFFFE SHALL make mem_addr run 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
REQ-039 A pop immediately after seek, while count=0, SHALL set underflow=1, hold it through later pushes, and clear it on the next seek.
REQ-040 RST_N pulsed low mid-fill (count=5, WAIT) SHALL drive all outputs to reset values; a late mem_ack SHALL be ignored; and with no seek, mem_rd SHALL stay 0 for 100 cycles.
